// File: rtl/scoreboard_pkg.sv
// Shared types and codes for the destination scoreboard.
// Entry layout, bypass select codes and the multdiv state type.
package scoreboard_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [1:0] SEL_REGFILE = 2'd0;
    localparam logic [1:0] SEL_XM      = 2'd1;
    localparam logic [1:0] SEL_MW      = 2'd2;
    localparam logic [1:0] SEL_W       = 2'd3;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } entry_t;

    localparam entry_t ENTRY_BUBBLE = '{
        valid:   1'b0,
        rd:      REG_ZERO,
        is_load: 1'b0
    };

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_t;

    // Youngest forwardable writer wins; a load in X has no data yet.
    function automatic logic [1:0] bypass_sel(
        input logic x_hit,
        input logic x_load,
        input logic m_hit,
        input logic w_hit
    );
        logic [1:0] sel;
        sel = SEL_REGFILE;
        if (x_hit && !x_load) begin
            sel = SEL_XM;
        end else if (m_hit) begin
            sel = SEL_MW;
        end else if (w_hit) begin
            sel = SEL_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sb_match.sv
// Entry-versus-source comparator for the destination scoreboard.
// Register 0 never produces a hit.
module sb_match
    import scoreboard_pkg::*;
(
    input  entry_t     ent,
    input  logic [4:0] src,
    input  logic       uses,
    output logic       hit
);

    assign hit = ent.valid & uses & (src != REG_ZERO) & (src == ent.rd);

endmodule

// File: rtl/dest_scoreboard.sv
// Decode hazard scoreboard: X/M/W writers plus one multdiv writer.
// SCOREBOARD_BYPASS_EN selects forwarding (load-use stall only).
module dest_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       issue_valid,
    input  logic       issue_has_dest,
    input  logic [4:0] issue_rd,
    input  logic [4:0] issue_rs,
    input  logic [4:0] issue_rt,
    input  logic       issue_uses_rs,
    input  logic       issue_uses_rt,
    input  logic       issue_is_load,
    input  logic       issue_is_multdiv,
    input  logic       md_done,
    input  logic       flush,
    output logic       stall,
    output logic [1:0] sel_rs,
    output logic [1:0] sel_rt,
    output logic       md_busy,
    output logic       md_timeout
);

    entry_t           ent_x;
    entry_t           ent_m;
    entry_t           ent_w;
    entry_t           issue_ent;
    entry_t           ents [4];
    md_state_t        md_state;
    logic [4:0]       md_rd;
    logic [CNT_W-1:0] md_cnt;
    logic             md_timeout_q;

    logic [3:0]       hit_rs;
    logic [3:0]       hit_rt;
    logic             md_hazard;
    logic             pipe_hazard;
    logic             stall_c;
    logic             wr_accept;
    logic             md_accept;
    logic             md_expire;
    logic             unused_bits;

    assign issue_ent = '{
        valid:   1'b1,
        rd:      issue_rd,
        is_load: issue_is_load
    };

    // Slot 3 is the outstanding multdiv writer.
    always_comb begin
        ents[0] = ent_x;
        ents[1] = ent_m;
        ents[2] = ent_w;
        ents[3] = '{
            valid:   md_busy,
            rd:      md_rd,
            is_load: 1'b0
        };
    end

    for (genvar g = 0; g < 4; g++) begin : g_match
        sb_match u_rs (
            .ent  (ents[g]),
            .src  (issue_rs),
            .uses (issue_uses_rs),
            .hit  (hit_rs[g])
        );
        sb_match u_rt (
            .ent  (ents[g]),
            .src  (issue_rt),
            .uses (issue_uses_rt),
            .hit  (hit_rt[g])
        );
    end

    // Second multdiv term is structural: one op outstanding at a time.
    assign md_hazard = md_busy & ~md_done
                     & (hit_rs[3] | hit_rt[3] | issue_is_multdiv);

`ifdef SCOREBOARD_BYPASS_EN
    assign pipe_hazard = (hit_rs[0] | hit_rt[0]) & ent_x.is_load;
    assign sel_rs = bypass_sel(hit_rs[0], ent_x.is_load,
                               hit_rs[1], hit_rs[2]);
    assign sel_rt = bypass_sel(hit_rt[0], ent_x.is_load,
                               hit_rt[1], hit_rt[2]);
`else
    // W needs no stall: the regfile writes before it is read.
    assign pipe_hazard = hit_rs[0] | hit_rs[1]
                       | hit_rt[0] | hit_rt[1];
    assign sel_rs = SEL_REGFILE;
    assign sel_rt = SEL_REGFILE;
`endif

    assign stall_c = issue_valid & ~flush & (md_hazard | pipe_hazard);
    assign stall   = stall_c;

    assign wr_accept = issue_valid & issue_has_dest
                     & (issue_rd != REG_ZERO)
                     & ~issue_is_multdiv & ~stall_c & ~flush;

    assign md_accept = issue_valid & issue_is_multdiv
                     & ~stall_c & ~flush;

    assign md_expire = md_busy & ~md_done
                     & (md_cnt == CNT_W'(MD_TIMEOUT - 1));

    assign md_busy    = (md_state == MD_BUSY);
    assign md_timeout = md_timeout_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            ent_x        <= ENTRY_BUBBLE;
            ent_m        <= ENTRY_BUBBLE;
            ent_w        <= ENTRY_BUBBLE;
            md_state     <= MD_IDLE;
            md_rd        <= REG_ZERO;
            md_cnt       <= '0;
            md_timeout_q <= 1'b0;
        end else begin
            ent_w <= ent_m;
            ent_m <= ent_x;
            ent_x <= wr_accept ? issue_ent : ENTRY_BUBBLE;

            // A new accept overrides a same-cycle md_done.
            if (md_accept) begin
                md_state <= MD_BUSY;
                md_rd    <= issue_rd;
                md_cnt   <= '0;
            end else begin
                unique case (md_state)
                    MD_IDLE: begin
                        md_cnt <= md_cnt;
                    end
                    MD_BUSY: begin
                        md_cnt <= md_cnt + 1'b1;
                        if (md_done) begin
                            md_state <= MD_IDLE;
                        end else if (md_expire) begin
                            md_state     <= MD_IDLE;
                            md_timeout_q <= 1'b1;
                        end
                    end
                    default: begin
                        md_state <= MD_IDLE;
                    end
                endcase
            end
        end
    end

    assign unused_bits = ^{ent_x.is_load, ent_m.is_load, ent_w.is_load,
                           hit_rs[2], hit_rt[2]};

endmodule

// File: tb/tb_dest_scoreboard.sv
// Testbench for dest_scoreboard: directed table, corner sequences, random.
// Expectations come from a cycle-stamped writer-history model.
module tb_dest_scoreboard;

    logic       clock = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic       issue_has_dest;
    logic [4:0] issue_rd;
    logic [4:0] issue_rs;
    logic [4:0] issue_rt;
    logic       issue_uses_rs;
    logic       issue_uses_rt;
    logic       issue_is_load;
    logic       issue_is_multdiv;
    logic       md_done;
    logic       flush;
    logic       stall;
    logic [1:0] sel_rs;
    logic [1:0] sel_rt;
    logic       md_busy;
    logic       md_timeout;

    dest_scoreboard #(
        .MD_TIMEOUT (64),
        .CNT_W      (7)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .issue_valid      (issue_valid),
        .issue_has_dest   (issue_has_dest),
        .issue_rd         (issue_rd),
        .issue_rs         (issue_rs),
        .issue_rt         (issue_rt),
        .issue_uses_rs    (issue_uses_rs),
        .issue_uses_rt    (issue_uses_rt),
        .issue_is_load    (issue_is_load),
        .issue_is_multdiv (issue_is_multdiv),
        .md_done          (md_done),
        .flush            (flush),
        .stall            (stall),
        .sel_rs           (sel_rs),
        .sel_rt           (sel_rt),
        .md_busy          (md_busy),
        .md_timeout       (md_timeout)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0] rd;
        bit         ld;
        int         cyc;
    } wr_t;

    wr_t        wq[$];
    int         cyc     = 0;
    bit         m_busy  = 0;
    logic [4:0] m_rd    = 0;
    int         m_start = 0;
    bit         m_to    = 0;
    bit         e_stall;
    int         e_rs;
    int         e_rt;

    function automatic int pick(bit h0, bit l0, bit h1, bit h2);
        if (h0 && !l0) return 1;
        if (h1) return 2;
        if (h2) return 3;
        return 0;
    endfunction

    task automatic model_eval();
        bit ha[3];
        bit hb[3];
        bit hl[3];
        bit mdh;
        bit pipe;
        int age;
        for (int s = 0; s < 3; s++) begin
            ha[s] = 0;
            hb[s] = 0;
            hl[s] = 0;
        end
        foreach (wq[k]) begin
            age = cyc - wq[k].cyc;
            if (age >= 0 && age <= 2) begin
                hl[age] = wq[k].ld;
                if (issue_uses_rs && issue_rs != 0 && issue_rs == wq[k].rd)
                    ha[age] = 1;
                if (issue_uses_rt && issue_rt != 0 && issue_rt == wq[k].rd)
                    hb[age] = 1;
            end
        end
        mdh = m_busy && !md_done &&
              ((issue_uses_rs && issue_rs != 0 && issue_rs == m_rd) ||
               (issue_uses_rt && issue_rt != 0 && issue_rt == m_rd) ||
               issue_is_multdiv);
`ifdef SCOREBOARD_BYPASS_EN
        pipe = (ha[0] || hb[0]) && hl[0];
        e_rs = pick(ha[0], hl[0], ha[1], ha[2]);
        e_rt = pick(hb[0], hl[0], hb[1], hb[2]);
`else
        pipe = ha[0] || ha[1] || hb[0] || hb[1];
        e_rs = 0;
        e_rt = 0;
`endif
        e_stall = issue_valid && !flush && (mdh || pipe);
    endtask

    task automatic model_update();
        bit acc_w;
        bit acc_m;
        if (reset) begin
            wq.delete();
            m_busy = 0;
            m_rd   = 0;
            m_to   = 0;
        end else begin
            acc_w = issue_valid && issue_has_dest && issue_rd != 0 &&
                    !issue_is_multdiv && !e_stall && !flush;
            acc_m = issue_valid && issue_is_multdiv && !e_stall && !flush;
            if (acc_w)
                wq.push_back('{rd: issue_rd, ld: issue_is_load, cyc: cyc + 1});
            if (acc_m) begin
                m_busy  = 1;
                m_rd    = issue_rd;
                m_start = cyc + 1;
            end else if (m_busy && md_done) begin
                m_busy = 0;
            end else if (m_busy && (cyc - m_start == 63)) begin
                m_busy = 0;
                m_to   = 1;
            end
        end
        cyc++;
        while (wq.size() > 0 && cyc - wq[0].cyc > 2)
            void'(wq.pop_front());
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        bit         v, hd;
        logic [4:0] rd, rs, rt;
        bit         urs, urt, ld, md, done, fl;
        bit         e_st;
        int         e_rs, e_rt;
        bit         e_busy, e_to;
    } vec_t;

    function automatic vec_t mk(
        bit v, bit hd, int rd, int rs, int rt, bit urs, bit urt,
        bit ld, bit md, bit done, bit fl,
        bit st, int srs, int srt, bit busy, bit to
    );
        vec_t t;
        t.v = v; t.hd = hd;
        t.rd = 5'(rd); t.rs = 5'(rs); t.rt = 5'(rt);
        t.urs = urs; t.urt = urt; t.ld = ld; t.md = md;
        t.done = done; t.fl = fl;
        t.e_st = st; t.e_rs = srs; t.e_rt = srt;
        t.e_busy = busy; t.e_to = to;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        issue_valid      = t.v;
        issue_has_dest   = t.hd;
        issue_rd         = t.rd;
        issue_rs         = t.rs;
        issue_rt         = t.rt;
        issue_uses_rs    = t.urs;
        issue_uses_rt    = t.urt;
        issue_is_load    = t.ld;
        issue_is_multdiv = t.md;
        md_done          = t.done;
        flush            = t.fl;
    endtask

    // One clock: compare at negedge, advance model at posedge.
    task automatic step(input bit use_tab, input vec_t t, input string tag);
        @(negedge clock);
        model_eval();
        chk({tag, " m_stall"}, int'(stall), int'(e_stall));
        chk({tag, " m_sel_rs"}, int'(sel_rs), e_rs);
        chk({tag, " m_sel_rt"}, int'(sel_rt), e_rt);
        chk({tag, " m_busy"}, int'(md_busy), int'(m_busy));
        chk({tag, " m_to"}, int'(md_timeout), int'(m_to));
        if (use_tab) begin
            chk({tag, " stall"}, int'(stall), int'(t.e_st));
            chk({tag, " sel_rs"}, int'(sel_rs), t.e_rs);
            chk({tag, " sel_rt"}, int'(sel_rt), t.e_rt);
            chk({tag, " busy"}, int'(md_busy), int'(t.e_busy));
            chk({tag, " to"}, int'(md_timeout), int'(t.e_to));
        end
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        vec_t idle;
        idle = mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
        drive(idle);
        reset = 1'b1;
        step(1'b0, idle, "rst");
        reset = 1'b0;
    endtask

    vec_t tv[$];
    vec_t cur;
    vec_t idle_v;

    initial begin
        idle_v = mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
        reset = 1'b1;
        drive(idle_v);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

`ifdef SCOREBOARD_BYPASS_EN
        tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,  0,0,0,0,0));
        tv.push_back(mk(1,1,3,1,2,1,1,0,0,0,0,  0,0,0,0,0));
        tv.push_back(mk(1,1,6,3,0,1,0,0,0,0,0,  0,1,0,0,0));
        tv.push_back(mk(1,1,8,3,0,1,0,0,0,0,0,  0,2,0,0,0));
        tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,  0,0,0,0,0));
        tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,  0,0,0,0,0));
        tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,  0,0,0,0,0));
        tv.push_back(mk(1,1,5,1,0,1,0,1,0,0,0,  0,0,0,0,0));
        tv.push_back(mk(1,1,9,0,5,0,1,0,0,0,0,  1,0,0,0,0));
        tv.push_back(mk(1,1,9,0,5,0,1,0,0,0,0,  0,0,2,0,0));
        tv.push_back(mk(1,0,0,1,0,1,0,0,0,0,0,  0,0,0,0,0));
        tv.push_back(mk(1,1,12,0,0,1,1,0,0,0,0, 0,0,0,0,0));
        tv.push_back(mk(1,0,10,0,0,0,0,0,0,0,0, 0,0,0,0,0));
        tv.push_back(mk(1,1,13,10,10,1,1,0,0,0,0, 0,0,0,0,0));
        tv.push_back(mk(1,1,7,1,2,1,1,0,1,0,0,  0,0,0,0,0));
        tv.push_back(mk(1,1,11,7,0,1,0,0,0,0,0, 1,0,0,1,0));
        tv.push_back(mk(1,1,11,7,0,1,0,0,0,0,0, 1,0,0,1,0));
        tv.push_back(mk(1,1,11,7,0,1,0,0,0,0,0, 1,0,0,1,0));
        tv.push_back(mk(1,1,11,7,0,1,0,0,0,1,0, 0,0,0,1,0));
        tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,  0,0,0,0,0));
`else
        tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,  0,0,0,0,0));
        tv.push_back(mk(1,1,4,1,2,1,1,0,0,0,0,  0,0,0,0,0));
        tv.push_back(mk(1,1,6,4,0,1,0,0,0,0,0,  1,0,0,0,0));
        tv.push_back(mk(1,1,6,4,0,1,0,0,0,0,0,  1,0,0,0,0));
        tv.push_back(mk(1,1,6,4,0,1,0,0,0,0,0,  0,0,0,0,0));
        tv.push_back(mk(1,1,13,6,0,1,0,0,0,0,1, 0,0,0,0,0));
        tv.push_back(mk(1,0,0,13,0,1,0,0,0,0,0, 0,0,0,0,0));
        tv.push_back(mk(1,1,14,0,0,0,0,0,0,0,1, 0,0,0,0,0));
        tv.push_back(mk(1,0,0,14,0,1,0,0,0,0,0, 0,0,0,0,0));
        tv.push_back(mk(1,0,0,1,0,1,0,0,0,0,0,  0,0,0,0,0));
        tv.push_back(mk(1,0,0,0,0,1,1,0,0,0,0,  0,0,0,0,0));
        tv.push_back(mk(1,1,7,1,2,1,1,0,1,0,0,  0,0,0,0,0));
        tv.push_back(mk(1,1,11,7,0,1,0,0,0,0,0, 1,0,0,1,0));
        tv.push_back(mk(1,1,11,7,0,1,0,0,0,0,0, 1,0,0,1,0));
        tv.push_back(mk(1,1,11,7,0,1,0,0,0,1,0, 0,0,0,1,0));
        tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,  0,0,0,0,0));
`endif

        foreach (tv[i]) begin
            drive(tv[i]);
            step(1'b1, tv[i], $sformatf("row%0d", i));
        end

        // Watchdog: second mul waits 64 cycles for the first to expire.
        do_reset();
        cur = mk(1,1,7,0,0,0,0,0,1,0,0, 0,0,0,0,0);
        drive(cur);
        step(1'b1, cur, "mul1");
        cur = mk(1,1,8,0,0,0,0,0,1,0,0, 1,0,0,1,0);
        drive(cur);
        for (int i = 0; i < 64; i++)
            step(1'b1, cur, $sformatf("md_wait%0d", i));
        cur = mk(1,1,8,0,0,0,0,0,1,0,0, 0,0,0,0,1);
        step(1'b1, cur, "md_expire");
        cur = mk(1,1,8,8,0,1,0,0,0,0,0, 1,0,0,1,1);
        drive(cur);
        step(1'b1, cur, "mul2_busy");

        // Reset drops the outstanding op and the sticky flag.
        drive(idle_v);
        reset = 1'b1;
        step(1'b0, idle_v, "rst_mid");
        reset = 1'b0;
        cur = mk(1,1,9,8,8,1,1,0,0,0,0, 0,0,0,0,0);
        drive(cur);
        step(1'b1, cur, "post_rst");

        for (int n = 0; n < 2500; n++) begin
            reset            = ($urandom_range(0, 299) == 0);
            issue_valid      = ($urandom_range(0, 3) != 0);
            issue_rd         = 5'($urandom_range(0, 7));
            issue_has_dest   = (issue_rd != 0) && ($urandom_range(0, 4) != 0);
            issue_rs         = 5'($urandom_range(0, 7));
            issue_rt         = 5'($urandom_range(0, 7));
            issue_uses_rs    = 1'($urandom_range(0, 1));
            issue_uses_rt    = 1'($urandom_range(0, 1));
            issue_is_load    = ($urandom_range(0, 3) == 0);
            issue_is_multdiv = ($urandom_range(0, 7) == 0);
            md_done          = ($urandom_range(0, 11) == 0);
            flush            = ($urandom_range(0, 9) == 0);
            step(1'b0, idle_v, $sformatf("rand%0d", n));
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dest_scoreboard.md
Name: dest_scoreboard

Overview:
- Hazard/scoreboard stage directly downstream of the per-instruction destination decode. Consumes `has_dest`, `rd`, source-register and class flags for the instruction leaving decode.
- Tracks in-flight writers in X, M and W, plus one long-latency multdiv writer.
- Produces the decode stall, per-source bypass selects and a multdiv watchdog flag for the 5-stage pipeline.

Parameters:
- MD_TIMEOUT, 64: cycles a multdiv may stay busy before the watchdog forces it clear.
- CNT_W, 7: width of the multdiv cycle counter; must satisfy 2^CNT_W > MD_TIMEOUT.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- issue_valid  in  1  decode holds a real instruction
- issue_has_dest  in  1  instruction writes `rd` (already false for `rd`=0)
- issue_rd  in  5  destination register
- issue_rs  in  5  source A
- issue_rt  in  5  source B
- issue_uses_rs  in  1  source A is read
- issue_uses_rt  in  1  source B is read
- issue_is_load  in  1  instruction is `lw`
- issue_is_multdiv  in  1  instruction is `mul`/`div`
- md_done  in  1  one-cycle pulse; multdiv result written this cycle
- flush  in  1  taken branch/jump in X; kill the decode slot
- stall  out  1  hold F/D, insert bubble into X
- sel_rs  out  2  bypass select for source A: 0 regfile, 1 X/M, 2 M/W, 3 W
- sel_rt  out  2  bypass select for source B, same encoding
- md_busy  out  1  multdiv writer outstanding
- md_timeout  out  1  sticky watchdog flag

Behaviour:
- Entry = {valid, rd[4:0], is_load}; three registers `ent_x`, `ent_m`, `ent_w`.
- Per-clock shift: `ent_w` <= `ent_m`; `ent_m` <= `ent_x`.
- `ent_x` is loaded with the issue entry only when `issue_valid` & `issue_has_dest` & `issue_rd`!=0 & !`issue_is_multdiv` & !`stall` & !`flush`. Otherwise `ent_x` loads a bubble (valid=0).
- `match(e, src, uses)` = `e.valid` & `uses` & `src`!=0 & `src`==`e.rd`. Register 0 is never a hazard.
- md_hazard = `md_busy` & !`md_done` & (source matches `md_rd`, or `issue_is_multdiv`). The second term is a structural hazard: only one multdiv may be outstanding.
- `stall` = `issue_valid` & !`flush` & (md_hazard | pipe_hazard), where pipe_hazard depends on the macro (see Optional Feature). `stall` is combinational, with zero-cycle latency.
- Multdiv sequence:
  - Accepted (`issue_valid` & `issue_is_multdiv` & !`stall` & !`flush`): `md_busy`<=1, `md_rd`<=`issue_rd`, `md_cnt`<=0.
  - While busy: `md_cnt` increments.
  - `md_done`: `md_busy`<=0.
  - `md_cnt`==MD_TIMEOUT-1 without `md_done`: `md_busy`<=0 and `md_timeout`<=1 (sticky until reset).
  - `md_done` and a new multdiv accept in the same cycle: new op wins (busy stays 1, reload).
  - `md_done` while not busy: ignored.
- `flush`: decode slot becomes a bubble, `stall` forced 0. X/M/W and multdiv state are unaffected.
- Reset: all entries invalid, `md_busy`=0, `md_cnt`=0, `md_rd`=0, `md_timeout`=0. Combinational outputs evaluate to 0 in the cycle after reset. Reset mid-multdiv drops the op silently.

Optional Feature:
- Macro SCOREBOARD_BYPASS_EN.
- Defined:
  - pipe_hazard = load-use only: `match(ent_x)` & `ent_x.is_load` on either source.
  - `sel_*` priority: X match & !`is_load` -> 1; else M match -> 2; else W match -> 3; else 0.
- Undefined:
  - pipe_hazard = any source matching `ent_x` or `ent_m`. W is covered by regfile write-before-read.
  - `sel_rs` = `sel_rt` = 0 always.

Decomposition:
- Package `scoreboard_pkg`:
  - entry struct typedef
  - SEL_* codes (REGFILE=0, XM=1, MW=2, W=3)
  - REG_ZERO=5'd0
- Natural sub-module: `sb_match` (combinational entry-vs-source comparator, instantiated per entry per source).
- Shift registers and multdiv FSM (IDLE/BUSY) stay in the top.

Test Plan:
- Bypass on: `add r3` issued, next cycle `sub` reads `rs`=r3 -> `stall`=0, `sel_rs`=1; following cycle reader of r3 -> `sel_rs`=2.
- `lw r5`, then `add` reading `rt`=r5 -> `stall`=1 for exactly one cycle; next cycle `sel_rt`=2, `stall`=0.
- `add r0` then reader of r0 -> no stall, `sel`=0. Writer with `issue_has_dest`=0 -> no hazard.
- `mul r7`, reader of r7 -> stall held; `md_done` at cycle 20 -> `stall` drops that same cycle; `md_busy`=0 next cycle.
- Second `mul` while busy -> stalled; no `md_done` for 64 cycles -> `md_timeout`=1, `md_busy`=0, second `mul` then accepted.
- Bypass off: writer r4 then reader r4 -> stall 2 cycles; `flush` asserted during a stalling cycle -> `stall`=0 and `ent_x` bubble; reset mid-multdiv -> all outputs 0.
